// File: rtl/buffer_read_scheduler.sv
// buffer_read_scheduler: paces reads from four packet buffers. After a
// programmable cooldown it picks the fullest buffer (ties rotate round-robin
// after the last buffer served), raises a one-hot read request and waits for
// the read logic to acknowledge, abandon on timeout, or see the buffer drained.
module buffer_read_scheduler #(
  parameter int TICK_DIV    = 150000000, // cooldown length in clk cycles, >= 2
  parameter int ACK_TIMEOUT = 16,        // request lifetime without ack, >= 1
  parameter int OCC_W       = 3          // occupancy count width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OCC_W-1:0] occ0,
  input  logic [OCC_W-1:0] occ1,
  input  logic [OCC_W-1:0] occ2,
  input  logic [OCC_W-1:0] occ3,
  input  logic             rd_ack,
  output logic [3:0]       rd_req,
  output logic [1:0]       rd_sel,
  output logic             busy,
  output logic [4:0]       pkt_count,
  output logic             err_timeout
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_REQ  = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       rd_req_q, rd_req_d;
  logic [1:0]       rd_sel_q, rd_sel_d;
  logic             busy_q, busy_d;
  logic [4:0]       pkt_q, pkt_d;
  logic             err_q, err_d;

  logic [3:0][OCC_W-1:0] occ_v;
  logic                  any_nz;
  logic [1:0]            pick_sel;
  logic                  sel_empty;

  assign occ_v     = {occ3, occ2, occ1, occ0};
  assign any_nz    = |{occ0, occ1, occ2, occ3};
  assign sel_empty = (occ_v[rd_sel_q] == '0);

  // Fullest buffer wins; scanning from last+1 with a strict compare makes the
  // earliest buffer in rotation order win any tie.
  function automatic logic [1:0] pick_fullest(input logic [3:0][OCC_W-1:0] occ_a,
                                               input logic [1:0] last);
    logic [1:0]       best;
    logic [1:0]       idx;
    logic [OCC_W-1:0] best_occ;
    best     = last + 2'd1;
    best_occ = occ_a[best];
    for (int k = 2; k <= 4; k++) begin
      idx = last + 2'(k);
      if (occ_a[idx] > best_occ) begin
        best     = idx;
        best_occ = occ_a[idx];
      end
    end
    return best;
  endfunction

  assign pick_sel = pick_fullest(occ_v, last_q);

  // Next-state and registered-output logic for the scheduler FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    last_d   = last_q;
    rd_req_d = rd_req_q;
    rd_sel_d = rd_sel_q;
    pkt_d    = pkt_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && any_nz) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (!any_nz) begin
          state_d = S_IDLE;
        end else begin
          rd_sel_d = pick_sel;
          rd_req_d = 4'b0001 << pick_sel;
          tmo_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_ack) begin
          pkt_d    = pkt_q + 5'd1;
          last_d   = rd_sel_q;
          rd_req_d = '0;
          cnt_d    = CNT_LOAD;
          state_d  = S_COOL;
        end else if (sel_empty) begin
          // Buffer drained by someone else: drop quietly, no cooldown.
          rd_req_d = '0;
          state_d  = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          last_d   = rd_sel_q;
          rd_req_d = '0;
          cnt_d    = CNT_LOAD;
          state_d  = S_COOL;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_COOL: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_ARB) || (state_d == S_REQ);
  end

  // State and output registers; reset also cancels any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      last_q   <= 2'd3;
      rd_req_q <= '0;
      rd_sel_q <= '0;
      busy_q   <= 1'b0;
      pkt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      last_q   <= last_d;
      rd_req_q <= rd_req_d;
      rd_sel_q <= rd_sel_d;
      busy_q   <= busy_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_sel      = rd_sel_q;
  assign busy        = busy_q;
  assign pkt_count   = pkt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_buffer_read_scheduler.sv
// Testbench for buffer_read_scheduler: transaction-level reference model
// (fullest buffer, rotating tie-break, served/timeout bookkeeping) driven by
// directed scenarios and randomized transactions.
module tb_buffer_read_scheduler;

  localparam int TICK_DIV    = 8;
  localparam int ACK_TIMEOUT = 4;
  localparam int OCC_W       = 3;

  localparam int M_ACK   = 0;
  localparam int M_EMPTY = 1;
  localparam int M_TMO   = 2;
  localparam int M_BOTH  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             rd_ack;
  logic [OCC_W-1:0] occ_b [4];
  logic [3:0]       rd_req;
  logic [1:0]       rd_sel;
  logic             busy;
  logic [4:0]       pkt_count;
  logic             err_timeout;

  int checks   = 0;
  int failures = 0;
  int last_m;
  int pkt_m;
  int err_m;
  int granted;

  buffer_read_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .OCC_W      (OCC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .occ0       (occ_b[0]),
    .occ1       (occ_b[1]),
    .occ2       (occ_b[2]),
    .occ3       (occ_b[3]),
    .rd_ack     (rd_ack),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .busy       (busy),
    .pkt_count  (pkt_count),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference choice: largest occupancy; among equals, the first one met
  // walking last+1, last+2, last+3, last.
  function automatic int model_pick(input int last);
    int mx;
    mx = 0;
    for (int i = 0; i < 4; i++)
      if (int'(occ_b[i]) > mx) mx = int'(occ_b[i]);
    for (int k = 1; k <= 4; k++)
      if (int'(occ_b[(last + k) % 4]) == mx) return (last + k) % 4;
    return 0;
  endfunction

  task automatic set_occ(input int a, input int b, input int c, input int d);
    occ_b[0] = OCC_W'(a);
    occ_b[1] = OCC_W'(b);
    occ_b[2] = OCC_W'(c);
    occ_b[3] = OCC_W'(d);
  endtask

  task automatic rand_occ;
    for (int i = 0; i < 4; i++) occ_b[i] = OCC_W'($urandom_range(0, 6));
    if (occ_b[0] == 0 && occ_b[1] == 0 && occ_b[2] == 0 && occ_b[3] == 0)
      occ_b[$urandom_range(0, 3)] = OCC_W'($urandom_range(1, 6));
  endtask

  task automatic do_reset;
    rst    = 1'b1;
    en     = 1'b0;
    rd_ack = 1'b0;
    tick;
    rst    = 1'b0;
    last_m = 3;
    pkt_m  = 0;
    err_m  = 0;
  endtask

  // One grant from IDLE: 2-cycle latency, request held until ack / drain /
  // timeout, then (for ack and timeout) a full cooldown with no activity.
  task automatic run_txn(input int mode, input int dly, input bit randomize_occ);
    int sel;
    bit fire;
    bit cooled;
    if (randomize_occ) rand_occ();
    en     = 1'b1;
    rd_ack = 1'b0;
    sel    = model_pick(last_m);
    tick;
    check_eq("arb_busy", 32'(busy), 32'd1);
    check_eq("arb_noreq", 32'(rd_req), 32'd0);
    tick;
    granted = int'(rd_sel);
    fire = 1'b0;
    for (int c = 0; c < ACK_TIMEOUT; c++) begin
      check_eq("req_onehot", 32'(rd_req), 32'(4'b0001 << sel));
      check_eq("req_sel", 32'(rd_sel), 32'(sel));
      check_eq("req_busy", 32'(busy), 32'd1);
      fire = (mode != M_TMO) && (c == dly);
      if (fire && (mode == M_ACK || mode == M_BOTH)) rd_ack = 1'b1;
      if (fire && (mode == M_EMPTY || mode == M_BOTH)) occ_b[sel] = '0;
      en = 1'($urandom_range(0, 1));
      tick;
      rd_ack = 1'b0;
      if (fire) break;
    end
    cooled = 1'b0;
    if (mode == M_ACK || mode == M_BOTH) begin
      pkt_m  = (pkt_m + 1) % 32;
      last_m = sel;
      cooled = 1'b1;
    end else if (mode == M_TMO) begin
      err_m  = 1;
      last_m = sel;
      cooled = 1'b1;
    end
    check_eq("drop_req", 32'(rd_req), 32'd0);
    check_eq("drop_busy", 32'(busy), 32'd0);
    check_eq("pkt_count", 32'(pkt_count), 32'(pkt_m));
    check_eq("err_timeout", 32'(err_timeout), 32'(err_m));
    if (cooled) begin
      en = 1'b1;
      for (int i = 0; i < TICK_DIV; i++) begin
        rd_ack = ($urandom_range(0, 3) == 0);
        tick;
        rd_ack = 1'b0;
        check_eq("cool_busy", 32'(busy), 32'd0);
        check_eq("cool_req", 32'(rd_req), 32'd0);
      end
      check_eq("cool_pkt", 32'(pkt_count), 32'(pkt_m));
    end
  endtask

  initial begin
    int r;
    rst    = 1'b1;
    en     = 1'b0;
    rd_ack = 1'b0;
    set_occ(0, 0, 0, 0);
    last_m = 3;
    pkt_m  = 0;
    err_m  = 0;
    tick;
    tick;
    check_eq("rst_req", 32'(rd_req), 32'd0);
    check_eq("rst_sel", 32'(rd_sel), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pkt", 32'(pkt_count), 32'd0);
    check_eq("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    // Enabled but nothing buffered: must stay idle.
    en = 1'b1;
    tick;
    tick;
    check_eq("idle_nodata_busy", 32'(busy), 32'd0);

    // Fullest buffer first.
    set_occ(2, 5, 1, 0);
    run_txn(M_ACK, 0, 1'b0);
    check_eq("fullest_sel", 32'(granted), 32'd1);

    // Equal occupancies rotate 0,1,2,3,0 from reset.
    do_reset();
    set_occ(3, 3, 3, 3);
    for (int i = 0; i < 5; i++) begin
      run_txn(M_ACK, 0, 1'b0);
      check_eq("tie_order", 32'(granted), 32'(i % 4));
    end
    check_eq("tie_pkt", 32'(pkt_count), 32'd5);

    // Timeout without ack.
    set_occ(0, 0, 4, 0);
    run_txn(M_TMO, 0, 1'b0);
    check_eq("tmo_sel", 32'(granted), 32'd2);
    check_eq("tmo_pkt", 32'(pkt_count), 32'd5);

    // Buffer drained during request.
    do_reset();
    set_occ(0, 0, 0, 1);
    run_txn(M_EMPTY, 1, 1'b0);
    check_eq("empty_err", 32'(err_timeout), 32'd0);

    // Disabled with data: no arbitration.
    set_occ(1, 0, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("en_low_req", 32'(rd_req), 32'd0);
      check_eq("en_low_busy", 32'(busy), 32'd0);
    end

    // Randomized transactions, occasionally with enable low first.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rand_occ();
        en = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
          tick;
          check_eq("rnd_en_low_busy", 32'(busy), 32'd0);
          check_eq("rnd_en_low_req", 32'(rd_req), 32'd0);
        end
      end
      r = int'($urandom_range(0, 9));
      if (r <= 5)      run_txn(M_ACK,   int'($urandom_range(0, ACK_TIMEOUT - 1)), 1'b1);
      else if (r <= 7) run_txn(M_EMPTY, int'($urandom_range(0, ACK_TIMEOUT - 1)), 1'b1);
      else if (r == 8) run_txn(M_TMO,   0, 1'b1);
      else             run_txn(M_BOTH,  int'($urandom_range(0, ACK_TIMEOUT - 1)), 1'b1);
    end

    // Counter wrap: 31 then 0.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      run_txn(M_ACK, int'($urandom_range(0, ACK_TIMEOUT - 1)), 1'b1);
      if (i == 30) check_eq("wrap_31", 32'(pkt_count), 32'd31);
    end
    check_eq("wrap_0", 32'(pkt_count), 32'd0);

    // Reset during an active request.
    run_txn(M_ACK, 0, 1'b1);
    run_txn(M_TMO, 0, 1'b1);
    set_occ(3, 3, 3, 3);
    en = 1'b1;
    tick;
    tick;
    check_eq("pre_rst_req_active", 32'(rd_req != 4'b0000), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("midrst_req", 32'(rd_req), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_pkt", 32'(pkt_count), 32'd0);
    check_eq("midrst_err", 32'(err_timeout), 32'd0);
    last_m = 3;
    pkt_m  = 0;
    err_m  = 0;
    run_txn(M_ACK, 0, 1'b0);
    check_eq("post_rst_sel", 32'(granted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_read_scheduler.md
Name: buffer_read_scheduler

Overview:
- Decides which of the four 18-bit packet buffers is drained next and when.
- Paces reads with a programmable cooldown. Picks the fullest buffer, breaking ties round-robin. Issues a one-hot read request and handshakes with the buffer read logic.
- Keeps a 5-bit served-packet counter for the display path, and a sticky timeout flag.

Parameters:
- TICK_DIV, 150000000, cooldown length in clk cycles between completed reads (3 s at 50 MHz); minimum 2.
- ACK_TIMEOUT, 16, max cycles a request stays asserted without rd_ack before it is abandoned; minimum 1.
- OCC_W, 3, width of each buffer occupancy count (buffers hold 0..6 packets).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scheduling enable; low blocks new arbitration only.
- occ0  input  OCC_W  packets currently held in buffer 1.
- occ1  input  OCC_W  packets currently held in buffer 2.
- occ2  input  OCC_W  packets currently held in buffer 3.
- occ3  input  OCC_W  packets currently held in buffer 4.
- rd_ack  input  1  one-cycle pulse from read logic: packet removed from the requested buffer.
- rd_req  output  4  one-hot read request, bit i = buffer i+1.
- rd_sel  output  2  index of the granted buffer; valid while rd_req is nonzero.
- busy  output  1  high in ARB or REQ.
- pkt_count  output  5  packets served; wraps 31->0.
- err_timeout  output  1  sticky flag; set when a request times out.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; cooldown counter cnt=0; last=3; rd_req=0; rd_sel=0; busy=0; pkt_count=0; err_timeout=0; timeout counter=0. Reset overrides everything, including an in-flight request; rd_req drops on the next edge.
- Only the outputs listed above are visible. All outputs are registered.
- FSM states: IDLE, ARB, REQ, COOL.
- IDLE:
  - If en=1 and any occ nonzero, go to ARB next cycle. Otherwise stay in IDLE.
  - After reset, the first read is not delayed by a cooldown.
- ARB (exactly 1 cycle, busy=1):
  - Select the buffer with the largest occ.
  - Ties are broken by priority order (last+1, last+2, last+3, last) mod 4.
  - Register the selection in rd_sel.
  - If all occ are zero at this cycle, return to IDLE and issue no request.
  - Otherwise go to REQ with rd_req = one-hot(rd_sel) from the first REQ cycle.
- REQ (busy=1):
  - rd_req stays held and constant until exit. The timeout counter starts at 0 on entry and increments each cycle.
  - rd_ack=1: pkt_count += 1 (mod 32); last <= rd_sel; rd_req <= 0; cnt <= TICK_DIV-1; go to COOL.
  - Otherwise, if occ[rd_sel]==0 (buffer emptied elsewhere): withdraw rd_req; go to IDLE. No count, no cooldown, no error.
  - Otherwise, if the timeout counter reaches ACK_TIMEOUT-1: err_timeout <= 1; withdraw rd_req; last <= rd_sel; cnt <= TICK_DIV-1; go to COOL.
  - Priority order: rd_ack, then empty, then timeout.
  - en going low during REQ does not abort the request.
- COOL:
  - cnt decrements each cycle; at cnt==0, go to IDLE.
  - Consecutive grants are therefore separated by at least TICK_DIV+1 cycles (ack edge to next rd_req assertion).
- rd_ack while not in REQ is ignored: no count change, no state change.
- rd_sel holds its last value outside REQ.
- Latency from IDLE with data present to rd_req asserted: 2 cycles (IDLE->ARB->REQ).
- err_timeout clears only on rst.

Test Plan:
- (Bench parameters: TICK_DIV=8, ACK_TIMEOUT=4.)
- Reset then occ=(2,5,1,0), en=1, ack 1 cycle after rd_req -> rd_req=4'b0010 two cycles after occ applied, rd_sel=1; pkt_count=1; next rd_req no earlier than 9 cycles after the ack.
- Tie handling: occ=(3,3,3,3) held constant, always ack -> grant order 0,1,2,3,0; pkt_count=5.
- Timeout: occ=(0,0,4,0), never ack -> rd_req=4'b0100 for exactly 4 cycles, then 0; err_timeout=1 and stays 1; pkt_count unchanged.
- Empty during REQ: occ3=1 granted, occ3 forced to 0 before ack -> rd_req drops next cycle; state returns to IDLE with no cooldown; pkt_count unchanged; err_timeout=0.
- en=0 with occ=(1,0,0,0) -> rd_req stays 0. en deasserted mid-REQ, then ack -> pkt_count increments; no further grant while en=0.
- Wrap and reset: 32 acked reads -> pkt_count goes 31->0. rst asserted mid-REQ -> next edge rd_req=0, busy=0, pkt_count=0.
